// File: rtl/ahim_config_pkg.sv
// Shared AHIM configuration: widths, depths and the rx loader state encoding.
package ahim_config_pkg;

   localparam int PIO_DATA_WIDTH       = 128;
   localparam int UINT16_WIDTH         = 16;
   localparam int BP_WORD_PAYLOAD      = PIO_DATA_WIDTH / UINT16_WIDTH;
   localparam int BREAKPOINT_RAM_DEPTH = 32;
   localparam int IMAGE_RAM_DEPTH      = 7812;
   localparam int MIN_STRIP_SIZE       = 20;
   localparam int RX_WD_SHIFT          = 8;
   localparam int RX_WD_DEPTH          = 16;
   localparam int BP_ADDR_W            = 5;
   localparam int IMG_ADDR_W           = 13;

   typedef enum logic [2:0] {
      RXL_IDLE   = 3'd0,
      RXL_CHECK  = 3'd1,
      RXL_RX_BP  = 3'd2,
      RXL_RX_IMG = 3'd3,
      RXL_DONE   = 3'd4,
      RXL_ERR    = 3'd5
   } rx_loader_state_e;

   // Number of PIO words needed to carry 'count' 16-bit breakpoints (0..32).
   function automatic logic [5:0] calc_bp_words(input logic [7:0] count);
      logic [8:0] w_sum;
      w_sum = 9'(count) + 9'(BP_WORD_PAYLOAD - 1);
      return 6'(w_sum / 9'(BP_WORD_PAYLOAD));
   endfunction

endpackage

// File: rtl/ahim_rx_watchdog.sv
// Idle-cycle watchdog: counts enabled cycles without a kick and flags expiry
// at max(payload,1) << SHIFT.
module ahim_rx_watchdog #(
   parameter int SHIFT = 8,
   parameter int DEPTH = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_enable,
   input  logic       i_kick,
   input  logic [7:0] i_payload,
   output logic       o_expired
);

   logic [DEPTH-1:0] r_cnt;
   logic [7:0]       w_payload;
   logic [DEPTH-1:0] w_limit;

   assign w_payload = (i_payload == 8'd0) ? 8'd1 : i_payload;
   assign w_limit   = {{(DEPTH-8){1'b0}}, w_payload} << SHIFT;

   // Expiry is flagged on the idle cycle that would bring the count to the limit;
   // a kick in that same cycle always wins.
   assign o_expired = i_enable && !i_kick && ((r_cnt + DEPTH'(1)) == w_limit);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (!i_enable || i_kick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + DEPTH'(1);
      end
   end

endmodule

// File: rtl/ahim_rx_loader.sv
// AHIM upload receiver: streams breakpoint words then image columns from the
// PIO input port into the two RAMs, with watchdog and parameter checking.
//
// state      | meaning
// RXL_IDLE   | waiting for start
// RXL_CHECK  | validating latched strip width
// RXL_RX_BP  | receiving breakpoint words
// RXL_RX_IMG | receiving image columns
// RXL_DONE   | last image write issued, done pulse
// RXL_ERR    | timeout or bad parameters, held until abort
module ahim_rx_loader
   import ahim_config_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      abort,
   input  logic [15:0]               strip_width,
   input  logic [7:0]                bp_count,
   input  logic [7:0]                wd_pio,
   input  logic [PIO_DATA_WIDTH-1:0] pio_in_data,
   input  logic                      pio_in_valid,
   output logic                      pio_in_ready,
   output logic                      bp_wr_en,
   output logic [BP_ADDR_W-1:0]      bp_wr_addr,
   output logic                      img_wr_en,
   output logic [IMG_ADDR_W-1:0]     img_wr_addr,
   output logic [PIO_DATA_WIDTH-1:0] wr_data,
   output logic                      busy,
   output logic                      done,
   output logic                      err_timeout,
   output logic                      err_param,
   output logic [15:0]               words_rx
);

   rx_loader_state_e r_state;
   rx_loader_state_e w_next;

   logic                      r_ready;
   logic [15:0]               r_strip_width;
   logic [5:0]                r_bp_words;
   logic [7:0]                r_wd_pio;
   logic [IMG_ADDR_W-1:0]     r_idx;
   logic                      r_bp_wr_en;
   logic [BP_ADDR_W-1:0]      r_bp_wr_addr;
   logic                      r_img_wr_en;
   logic [IMG_ADDR_W-1:0]     r_img_wr_addr;
   logic [PIO_DATA_WIDTH-1:0] r_wr_data;
   logic                      r_err_timeout;
   logic                      r_err_param;
   logic [15:0]               r_words_rx;

   logic w_rx_active;
   logic w_xfer;
   logic w_bp_last;
   logic w_img_last;
   logic w_param_bad;
   logic w_expired;
   logic w_start_ok;

   assign w_rx_active = (r_state == RXL_RX_BP) || (r_state == RXL_RX_IMG);
   // Abort suppresses the transfer so nothing new is written after it.
   assign w_xfer      = pio_in_valid && r_ready && w_rx_active && !abort;
   assign w_bp_last   = (r_idx[5:0] == (r_bp_words - 6'd1));
   assign w_img_last  = ({3'b000, r_idx} == (r_strip_width - 16'd1));
   assign w_param_bad = (r_strip_width < 16'(MIN_STRIP_SIZE)) ||
                        (r_strip_width > 16'(IMAGE_RAM_DEPTH));
   assign w_start_ok  = start && !abort && (r_state == RXL_IDLE);

   ahim_rx_watchdog #(
      .SHIFT (RX_WD_SHIFT),
      .DEPTH (RX_WD_DEPTH)
   ) u_rx_watchdog (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_enable  (w_rx_active),
      .i_kick    (w_xfer),
      .i_payload (r_wd_pio),
      .o_expired (w_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= RXL_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         RXL_IDLE: begin
            if (start) w_next = RXL_CHECK;
         end
         RXL_CHECK: begin
            if (w_param_bad)              w_next = RXL_ERR;
            else if (r_bp_words == 6'd0)  w_next = RXL_RX_IMG;
            else                          w_next = RXL_RX_BP;
         end
         RXL_RX_BP: begin
            if (w_xfer && w_bp_last) w_next = RXL_RX_IMG;
            else if (w_expired)      w_next = RXL_ERR;
         end
         RXL_RX_IMG: begin
            if (w_xfer && w_img_last) w_next = RXL_DONE;
            else if (w_expired)       w_next = RXL_ERR;
         end
         RXL_DONE: w_next = RXL_IDLE;
         RXL_ERR:  w_next = RXL_ERR;
         default:  w_next = RXL_IDLE;
      endcase
      if (abort) w_next = RXL_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ready       <= 1'b0;
         r_strip_width <= '0;
         r_bp_words    <= '0;
         r_wd_pio      <= '0;
         r_idx         <= '0;
         r_bp_wr_en    <= 1'b0;
         r_bp_wr_addr  <= '0;
         r_img_wr_en   <= 1'b0;
         r_img_wr_addr <= '0;
         r_wr_data     <= '0;
         r_err_timeout <= 1'b0;
         r_err_param   <= 1'b0;
         r_words_rx    <= '0;
      end else begin
         r_ready     <= (w_next == RXL_RX_BP) || (w_next == RXL_RX_IMG);
         r_bp_wr_en  <= w_xfer && (r_state == RXL_RX_BP);
         r_img_wr_en <= w_xfer && (r_state == RXL_RX_IMG);

         if (w_xfer) begin
            r_wr_data <= pio_in_data;
            if (r_state == RXL_RX_BP) r_bp_wr_addr  <= r_idx[BP_ADDR_W-1:0];
            else                      r_img_wr_addr <= r_idx;
         end

         // One index serves both phases; it restarts when the image phase begins.
         if (r_state == RXL_CHECK) begin
            r_idx <= '0;
         end else if (w_xfer) begin
            if ((r_state == RXL_RX_BP) && w_bp_last) r_idx <= '0;
            else                                     r_idx <= r_idx + 13'd1;
         end

         if (w_start_ok) begin
            r_strip_width <= strip_width;
            r_bp_words    <= calc_bp_words(bp_count);
            r_wd_pio      <= wd_pio;
         end

         if (abort) begin
            r_err_timeout <= 1'b0;
            r_err_param   <= 1'b0;
            r_words_rx    <= '0;
         end else begin
            if (w_start_ok)
               r_words_rx <= '0;
            else if (w_xfer && (r_words_rx != 16'hFFFF))
               r_words_rx <= r_words_rx + 16'd1;
            if ((r_state == RXL_CHECK) && w_param_bad)
               r_err_param <= 1'b1;
            if (w_rx_active && w_expired && !w_xfer)
               r_err_timeout <= 1'b1;
         end
      end
   end

   assign pio_in_ready = r_ready;
   assign bp_wr_en     = r_bp_wr_en;
   assign bp_wr_addr   = r_bp_wr_addr;
   assign img_wr_en    = r_img_wr_en;
   assign img_wr_addr  = r_img_wr_addr;
   assign wr_data      = r_wr_data;
   assign busy         = (r_state != RXL_IDLE) && (r_state != RXL_DONE);
   assign done         = (r_state == RXL_DONE);
   assign err_timeout  = r_err_timeout;
   assign err_param    = r_err_param;
   assign words_rx     = r_words_rx;

endmodule

// File: tb/tb_ahim_rx_loader.sv
// Scoreboard bench for ahim_rx_loader: directed uploads push expected RAM
// writes; a negedge monitor pops and compares each write/done it sees.
module tb_ahim_rx_loader;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic         abort;
   logic [15:0]  strip_width;
   logic [7:0]   bp_count;
   logic [7:0]   wd_pio;
   logic [127:0] pio_in_data;
   logic         pio_in_valid;
   logic         pio_in_ready;
   logic         bp_wr_en;
   logic [4:0]   bp_wr_addr;
   logic         img_wr_en;
   logic [12:0]  img_wr_addr;
   logic [127:0] wr_data;
   logic         busy;
   logic         done;
   logic         err_timeout;
   logic         err_param;
   logic [15:0]  words_rx;

   ahim_rx_loader dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .abort        (abort),
      .strip_width  (strip_width),
      .bp_count     (bp_count),
      .wd_pio       (wd_pio),
      .pio_in_data  (pio_in_data),
      .pio_in_valid (pio_in_valid),
      .pio_in_ready (pio_in_ready),
      .bp_wr_en     (bp_wr_en),
      .bp_wr_addr   (bp_wr_addr),
      .img_wr_en    (img_wr_en),
      .img_wr_addr  (img_wr_addr),
      .wr_data      (wr_data),
      .busy         (busy),
      .done         (done),
      .err_timeout  (err_timeout),
      .err_param    (err_param),
      .words_rx     (words_rx)
   );

   typedef struct {
      bit           is_img;
      logic [12:0]  addr;
      logic [127:0] data;
      bit           last;
      longint       cyc;
   } exp_t;

   exp_t   q[$];
   int     n_checks  = 0;
   int     n_fail    = 0;
   int     done_seen = 0;
   int     exp_dones = 0;
   longint cyc       = 0;
   int     g_k, g_bpw, g_sw;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic logic [127:0] mk(input logic [7:0] tid, input int k);
      logic [15:0] w;
      w = {tid, 8'(k)};
      return {8{w}};
   endfunction

   // Monitor: every write or done pulse must match the head of the queue.
   always @(negedge clk) begin
      if (rst_n && (bp_wr_en || img_wr_en || done)) begin
         exp_t        e;
         logic [12:0] a_addr;
         if (done) done_seen++;
         a_addr = bp_wr_en ? {8'b0, bp_wr_addr} : img_wr_addr;
         if (q.size() == 0) begin
            chk("unexpected_write", {16'b0, bp_wr_en, img_wr_en, done, a_addr, wr_data}, 160'b0);
         end else begin
            e = q.pop_front();
            chk("wr_fields", {16'b0, bp_wr_en, img_wr_en, done, a_addr, wr_data},
                {16'b0, !e.is_img, e.is_img, e.last, e.addr, e.data});
            chk("wr_cycle", 160'(cyc), 160'(e.cyc));
         end
      end
   end

   task automatic do_start(input logic [15:0] sw, input logic [7:0] bpc,
                           input logic [7:0] wd, input int exp_bpw);
      strip_width = sw; bp_count = bpc; wd_pio = wd;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      g_k = 0; g_bpw = exp_bpw; g_sw = int'(sw);
      chk("start_words_clr", 160'(words_rx), 160'(0));
      chk("start_busy", 160'(busy), 160'(1));
   endtask

   // Called at a negedge; returns at the negedge right after the transfer edge.
   task automatic send_word(input logic [127:0] d);
      int   guard;
      exp_t e;
      guard = 0;
      pio_in_valid = 1'b1;
      pio_in_data  = d;
      while (!pio_in_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!pio_in_ready) begin
         chk("ready_wait", 160'(pio_in_ready), 160'(1));
         pio_in_valid = 1'b0;
         return;
      end
      e.is_img = (g_k >= g_bpw);
      e.addr   = e.is_img ? 13'(g_k - g_bpw) : 13'(g_k);
      e.last   = e.is_img && ((g_k - g_bpw) == (g_sw - 1));
      e.data   = d;
      e.cyc    = cyc + 1;
      q.push_back(e);
      if (e.last) exp_dones++;
      g_k++;
      @(negedge clk);
      pio_in_valid = 1'b0;
   endtask

   task automatic do_abort();
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic saw_ready;
      int   w;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      strip_width = '0; bp_count = '0; wd_pio = '0;
      pio_in_data = '0; pio_in_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ctrl", {152'b0, pio_in_ready, bp_wr_en, img_wr_en, busy, done,
                       err_timeout, err_param, 1'b0}, 160'b0);
      chk("rst_data", {14'b0, bp_wr_addr, img_wr_addr, wr_data}, 160'b0);
      chk("rst_words", 160'(words_rx), 160'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // 16 breakpoints (2 words) + 20 columns, valid back to back.
      do_start(16'd20, 8'd16, 8'd1, 2);
      for (int k = 0; k < 22; k++) send_word(mk(8'h11, k));
      repeat (2) @(negedge clk);
      chk("t1_done_cnt", 160'(done_seen), 160'(1));
      chk("t1_words", 160'(words_rx), 160'(22));
      chk("t1_busy", 160'(busy), 160'(0));

      // No breakpoints: straight to the image RAM.
      do_start(16'd20, 8'd0, 8'd1, 0);
      for (int k = 0; k < 20; k++) send_word(mk(8'h22, k));
      repeat (2) @(negedge clk);
      chk("t2_done_cnt", 160'(done_seen), 160'(2));
      chk("t2_words", 160'(words_rx), 160'(20));

      // Watchdog: 255 idle cycles tolerated, the 256th expires.
      do_start(16'd20, 8'd9, 8'd1, 2);
      send_word(mk(8'h33, 0));
      repeat (255) @(negedge clk);
      chk("t3_idle255_err", 160'(err_timeout), 160'(0));
      chk("t3_idle255_rdy", 160'(pio_in_ready), 160'(1));
      for (int k = 1; k < 4; k++) send_word(mk(8'h33, k));
      repeat (255) @(negedge clk);
      chk("t3_pre_expiry", 160'(err_timeout), 160'(0));
      @(negedge clk);
      chk("t3_expired", 160'(err_timeout), 160'(1));
      chk("t3_ready_drop", 160'(pio_in_ready), 160'(0));
      pio_in_valid = 1'b1;
      saw_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         saw_ready = saw_ready | pio_in_ready;
      end
      pio_in_valid = 1'b0;
      chk("t3_err_no_ready", 160'(saw_ready), 160'(0));
      chk("t3_words", 160'(words_rx), 160'(4));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("t3_start_in_err", {158'b0, busy, err_timeout}, {158'b0, 1'b1, 1'b1});
      do_abort();
      chk("t3_abort_clr", {157'b0, busy, err_timeout, err_param}, 160'b0);

      // Illegal strip widths: 19 and 7813.
      for (int t = 0; t < 2; t++) begin
         strip_width = (t == 0) ? 16'd19 : 16'd7813;
         bp_count = 8'd8; wd_pio = 8'd1;
         pio_in_valid = 1'b1;
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         chk("tp_err_early", 160'(err_param), 160'(0));
         @(negedge clk);
         chk("tp_err_param", 160'(err_param), 160'(1));
         saw_ready = pio_in_ready;
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            saw_ready = saw_ready | pio_in_ready;
         end
         chk("tp_no_ready", 160'(saw_ready), 160'(0));
         pio_in_valid = 1'b0;
         do_abort();
         chk("tp_abort_clr", {158'b0, busy, err_param}, 160'b0);
         chk("tp_words", 160'(words_rx), 160'(0));
      end

      // wd_pio=0 acts as 1; a start pulse in RX_BP must not disturb addresses.
      do_start(16'd20, 8'd16, 8'd0, 2);
      send_word(mk(8'h44, 0));
      start = 1'b1;
      send_word(mk(8'h44, 1));
      start = 1'b0;
      for (int k = 2; k < 5; k++) send_word(mk(8'h44, k));
      repeat (255) @(negedge clk);
      chk("t4_pre_expiry", 160'(err_timeout), 160'(0));
      @(negedge clk);
      chk("t4_expired", {158'b0, err_timeout, pio_in_ready}, {158'b0, 1'b1, 1'b0});
      chk("t4_words", 160'(words_rx), 160'(5));
      do_abort();

      // Abort after 5 image transfers, with valid still high.
      do_start(16'd20, 8'd0, 8'd1, 0);
      for (int k = 0; k < 5; k++) send_word(mk(8'h55, k));
      abort = 1'b1;
      pio_in_valid = 1'b1;
      pio_in_data = mk(8'h55, 5);
      @(negedge clk);
      abort = 1'b0;
      pio_in_valid = 1'b0;
      chk("t5_abort_idle", {158'b0, busy, pio_in_ready}, 160'b0);
      chk("t5_abort_words", 160'(words_rx), 160'(0));
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk("t5_abort_beats_start", 160'(busy), 160'(0));
      do_start(16'd20, 8'd0, 8'd1, 0);
      send_word(mk(8'h66, 0));
      @(negedge clk);
      chk("t5_restart_words", 160'(words_rx), 160'(1));
      do_abort();

      w = 0;
      while (q.size() != 0 && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("queue_empty", 160'(q.size()), 160'(0));
      chk("done_total", 160'(done_seen), 160'(exp_dones));
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
